// File: rtl/silife_spi_pkg.sv
// Shared types and constants for the SiLife SPI master engine.
// The receive path is enabled by the SILIFE_SPI_MISO_EN macro (see silife_spi_engine).
package silife_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_TRAIL = 2'd3
  } spi_state_e;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/silife_spi_if.sv
// Control/handshake and serial pin bundle between the grid controller and the SPI engine.
interface silife_spi_if #(
  parameter int WIDTH = 16,
  parameter int DIV_W = 8
);
  logic [WIDTH-1:0] i_word;
  logic             i_start;
  logic [DIV_W-1:0] i_div;
  logic             i_cpol;
  logic             i_cpha;
  logic             i_miso;
  logic             o_sck;
  logic             o_mosi;
  logic             o_cs_n;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_rx_word;

  modport master (
    output i_word, i_start, i_div, i_cpol, i_cpha, i_miso,
    input  o_sck, o_mosi, o_cs_n, o_busy, o_done, o_rx_word
  );

  modport slave (
    input  i_word, i_start, i_div, i_cpol, i_cpha, i_miso,
    output o_sck, o_mosi, o_cs_n, o_busy, o_done, o_rx_word
  );
endinterface

// File: rtl/silife_spi_clkdiv.sv
// Loadable down-counter: while enabled, emits a one-cycle tick every div+1 cycles.
// An all-ones divider gives 2^DIV_W cycles without widening the counter.
module silife_spi_clkdiv #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] reload_q, reload_d;

  assign tick_o = en_i && (cnt_q == {DIV_W{1'b0}});

  // Next count: load wins, then reload on tick, else count down while enabled
  always_comb begin
    cnt_d    = cnt_q;
    reload_d = reload_q;
    if (load_i) begin
      reload_d = div_i;
      cnt_d    = div_i;
    end else if (tick_o) begin
      cnt_d = reload_q;
    end else if (en_i) begin
      cnt_d = cnt_q - {{(DIV_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter and reload registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= {DIV_W{1'b0}};
      reload_q <= {DIV_W{1'b0}};
    end else begin
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
    end
  end

endmodule

// File: rtl/silife_spi_engine.sv
// Parametrised SPI master: MSB-first, CPOL/CPHA modes, programmable SCK divider, CS guard times.
// Define SILIFE_SPI_MISO_EN to build the full-duplex MISO capture path.
module silife_spi_engine
  import silife_spi_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIV_W = 8
) (
  input logic        clk,
  input logic        reset_n,
  silife_spi_if.slave bus
);

  localparam int               CNT_W     = $clog2(2*WIDTH+1);
  localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2*WIDTH-1);

  spi_state_e       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic             cpha_q, cpha_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             cs_n_q, cs_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick_s, load_s, lead_s, sample_s, finish_s;

  silife_spi_clkdiv #(.DIV_W(DIV_W)) u_clkdiv (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (load_s),
    .en_i    (state_q != ST_IDLE),
    .div_i   (bus.i_div),
    .tick_o  (tick_s)
  );

  // Transaction sequencing and next values of all serial outputs
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    edge_d   = edge_q;
    cpha_d   = cpha_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    cs_n_d   = cs_n_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    load_s   = 1'b0;
    lead_s   = ~edge_q[0];
    sample_s = 1'b0;
    finish_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sck_d  = bus.i_cpol;
        mosi_d = 1'b0;
        cs_n_d = 1'b1;
        busy_d = 1'b0;
        if (bus.i_start) begin
          load_s  = 1'b1;
          cpha_d  = bus.i_cpha;
          edge_d  = {CNT_W{1'b0}};
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_LEAD;
          // CPHA=0 presents the MSB with CS; CPHA=1 waits for the first leading edge
          if (bus.i_cpha) begin
            shift_d = bus.i_word;
            mosi_d  = 1'b0;
          end else begin
            shift_d = {bus.i_word[WIDTH-2:0], 1'b0};
            mosi_d  = bus.i_word[WIDTH-1];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LEAD: begin
        if (tick_s) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_LEAD;
        end
      end
      ST_SHIFT: begin
        if (tick_s) begin
          sck_d    = ~sck_q;
          edge_d   = edge_q + {{(CNT_W-1){1'b0}}, 1'b1};
          sample_s = (lead_s != cpha_q);
          if ((lead_s == cpha_q) && (edge_q != LAST_EDGE)) begin
            mosi_d  = shift_q[WIDTH-1];
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
          end else begin
            mosi_d  = mosi_q;
            shift_d = shift_q;
          end
          if (edge_q == LAST_EDGE) begin
            state_d = ST_TRAIL;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_TRAIL: begin
        if (tick_s) begin
          state_d  = ST_IDLE;
          cs_n_d   = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          mosi_d   = 1'b0;
          finish_s = 1'b1;
        end else begin
          state_d = ST_TRAIL;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      shift_q <= {WIDTH{1'b0}};
      edge_q  <= {CNT_W{1'b0}};
      cpha_q  <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      edge_q  <= edge_d;
      cpha_q  <= cpha_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_sck  = sck_q;
  assign bus.o_mosi = mosi_q;
  assign bus.o_cs_n = cs_n_q;
  assign bus.o_busy = busy_q;
  assign bus.o_done = done_q;

`ifdef SILIFE_SPI_MISO_EN
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0] rx_word_q, rx_word_d;

  // MISO capture; the completed word is published together with o_done
  always_comb begin
    rx_sh_d   = rx_sh_q;
    rx_word_d = rx_word_q;
    if (load_s) begin
      rx_sh_d = {WIDTH{1'b0}};
    end else if (sample_s) begin
      rx_sh_d = {rx_sh_q[WIDTH-2:0], bus.i_miso};
    end else begin
      rx_sh_d = rx_sh_q;
    end
    if (finish_s) begin
      rx_word_d = rx_sh_q;
    end else begin
      rx_word_d = rx_word_q;
    end
  end

  // Receive registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_sh_q   <= {WIDTH{1'b0}};
      rx_word_q <= {WIDTH{1'b0}};
    end else begin
      rx_sh_q   <= rx_sh_d;
      rx_word_q <= rx_word_d;
    end
  end

  assign bus.o_rx_word = rx_word_q;
`else
  logic unused_rx;
  assign unused_rx     = bus.i_miso ^ sample_s ^ finish_s;
  assign bus.o_rx_word = {WIDTH{1'b0}};
`endif

endmodule

// File: doc/silife_spi_engine.md
# silife_spi_engine

Parametrised SPI master, successor to the fixed 16-bit mode-0 shifter. It transmits a WIDTH-bit word MSB-first with a runtime-programmable SCK divider, all four CPOL/CPHA modes, and an active-low chip select with setup and hold guard intervals. An optional full-duplex receive path captures MISO. It sits between the SiLife grid controller and external SPI peripherals such as display drivers and shift-register chains, and uses the same start/busy handshake as the rest of the design.

## Interface
Parameters:
- WIDTH, 16: bits per transaction (≥2).
- DIV_W, 8: width of the divider input.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_word  in  WIDTH  transmit word, sampled on accepted start.
- i_start  in  1  start request, accepted only when o_busy=0.
- i_div  in  DIV_W  SCK half-period is H = i_div+1 clk cycles, sampled on start.
- i_cpol  in  1  SCK idle level, sampled on start.
- i_cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; sampled on start.
- i_miso  in  1  serial input (used only with the receive path).
- o_sck  out  1  serial clock.
- o_mosi  out  1  serial output.
- o_cs_n  out  1  chip select, active low.
- o_busy  out  1  transaction in progress.
- o_done  out  1  one-cycle pulse when a transaction ends.
- o_rx_word  out  WIDTH  last received word.

## Operation
- State machine: IDLE → LEAD → SHIFT → TRAIL → IDLE.
- IDLE: o_cs_n=1 and o_busy=0. o_sck is registered from i_cpol every cycle. o_mosi=0.
- Accepted start (IDLE and i_start=1):
  - latch i_word into the shift register, and latch i_div, i_cpol and i_cpha;
  - next cycle: o_busy=1, o_cs_n=0, state LEAD;
  - if CPHA=0, o_mosi = word[WIDTH-1] in the same cycle.
- LEAD: lasts H cycles with SCK at CPOL, then enter SHIFT.
- SHIFT: 2·WIDTH SCK toggles, one every H cycles.
  - CPHA=0: sample MISO on odd (leading) edges; drive the next bit on even (trailing) edges, except after the final edge.
  - CPHA=1: drive the next bit on leading edges; sample MISO on trailing edges.
  - After the last edge SCK is back at CPOL; enter TRAIL.
- TRAIL: H cycles with o_cs_n still 0. Then in one cycle: o_cs_n=1, o_busy=0, o_done=1, o_mosi=0, and o_rx_word updated.
- i_start while o_busy=1 is ignored. Changes to i_word, i_div, i_cpol or i_cpha during a transaction have no effect.
- i_start in the o_done cycle is accepted, giving back-to-back transfers with a minimum of one cycle of o_cs_n=1.
- Divider counter width is DIV_W. i_div=all-ones gives H=2^DIV_W with no overflow.

## Timing
- Reset values: o_sck=0, o_mosi=0, o_cs_n=1, o_busy=0, o_done=0, o_rx_word=0. Internal state is IDLE.
- Reset mid-transaction forces reset values immediately (asynchronously). No o_done is produced and o_rx_word is not updated.
- Start-to-busy latency: 1 cycle.
- o_busy high time: exactly (2·WIDTH+2)·H cycles.
- MOSI changes only on the driving SCK edge cycle, or on CS assertion for CPHA=0. It is stable for at least H cycles around each sampling edge.
- o_done is high for exactly 1 cycle, in the first IDLE cycle.

## Configuration
- SILIFE_SPI_MISO_EN defined: a MISO capture shift register is built; o_rx_word holds the word received MSB-first, updated with o_done.
- SILIFE_SPI_MISO_EN undefined: no receive logic is built; i_miso is unused and o_rx_word is tied to 0.

## Structure
- Package silife_spi_pkg holds:
  - the state typedef (IDLE/LEAD/SHIFT/TRAIL);
  - mode constants SPI_MODE0..3 as {cpol,cpha} 2-bit values.
- Sub-module silife_spi_clkdiv: a loadable down-counter producing a one-cycle tick every H cycles while enabled. The engine instantiates one.

## Test plan
- WIDTH=16, i_div=0, mode 0, i_word=16'hA5C3:
  - MOSI sampled on SCK rising edges reads A5C3;
  - o_busy is high for 34 cycles;
  - o_done pulses once;
  - o_cs_n is low for 34 cycles.
- With SILIFE_SPI_MISO_EN, MISO looped to MOSI, mode 1, i_word=16'h1234 → o_rx_word=16'h1234 in the o_done cycle.
- Mode 3, i_div=2, i_word=16'hFFFF:
  - o_sck idles high;
  - MOSI changes only on falling edges;
  - o_busy is high for 102 cycles.
- Second i_start 5 cycles into a transfer with a different word → ignored. Transmitted bits and busy length are unchanged.
- reset_n low at cycle 10 of a transfer → outputs go to reset values immediately with no o_done. A new start after release transfers correctly.
- i_start held high continuously, i_div=0 → back-to-back transactions with o_cs_n high for exactly 1 cycle between them, and o_done once per word.
